// File: rtl/repeated_adder.sv
// Purpose: unsigned N x N multiplier that adds A to an accumulator B times.
// Latency: done rises B+1 cycles after start is sampled (1 to 2^N cycles).
// Backpressure: none; start is ignored while busy, and the result holds until the next start.
//
// Ports:
//   i_clk      single clock; state changes on the rising edge
//   i_reset    asynchronous, active-high reset
//   i_start    begins a multiplication; sampled in IDLE or DONE, ignored in CALC
//   i_a        multiplicand, unsigned, N bits
//   i_b        multiplier and repeat count, unsigned, N bits
//   o_product  registered result A*B, 2N bits
//   o_done     high while o_product holds a valid result
module repeated_adder #(
  parameter int N = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_product,
  output logic           o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_cnt;
  logic [2*N-1:0] r_product;
  logic           r_done;

  logic [N-1:0]   w_a;
  logic [N-1:0]   w_cnt;
  logic [2*N-1:0] w_product;
  logic           w_done;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_a       <= w_a;
      r_cnt     <= w_cnt;
      r_product <= w_product;
      r_done    <= w_done;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_a          = r_a;
    w_cnt        = r_cnt;
    w_product    = r_product;
    w_done       = r_done;
    case (r_state)
      // A start taken from DONE clears done on the same edge, so results
      // can be requested back to back without passing through IDLE.
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_a          = i_a;
          w_cnt        = i_b;
          w_product    = '0;
          w_done       = 1'b0;
          w_next_state = S_CALC;
        end
      end
      // One extra cycle is spent at cnt==0 to raise done, which gives the
      // B+1 latency; a 2N-bit accumulator cannot overflow for N-bit operands.
      S_CALC: begin
        if (r_cnt != '0) begin
          w_product = r_product + {{N{1'b0}}, r_a};
          w_cnt     = r_cnt - N'(1);
        end else begin
          w_done       = 1'b1;
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign o_product = r_product;
  assign o_done    = r_done;

endmodule

// File: tb/tb_repeated_adder.sv
module tb_repeated_adder;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [7:0] product;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         exp_product;
    int         exp_lat;
  } vec_t;

  repeated_adder #(.N(4)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_a       (a_in),
    .i_b       (b_in),
    .o_product (product),
    .o_done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Start one operation, scramble A/B after it is sampled, measure latency
  // to done, then confirm the result is held while start stays low.
  task automatic run_op(input string nm, input logic [3:0] a, input logic [3:0] b,
                        input int exp_p, input int exp_lat);
    int cycles;
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    chk({nm, " done low after start"}, int'(done), 0);
    cycles = 0;
    while (cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) break;
    end
    chk({nm, " latency"}, cycles, exp_lat);
    chk({nm, " product"}, int'(product), exp_p);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " done held"}, int'(done), 1);
    chk({nm, " product held"}, int'(product), exp_p);
  endtask

  initial begin
    vec_t vecs[8];
    int   cycles;
    int   saw_done;

    vecs[0] = '{a: 4'd3,  b: 4'd4,  exp_product: 12,  exp_lat: 5};
    vecs[1] = '{a: 4'd7,  b: 4'd5,  exp_product: 35,  exp_lat: 6};
    vecs[2] = '{a: 4'd15, b: 4'd15, exp_product: 225, exp_lat: 16};
    vecs[3] = '{a: 4'd9,  b: 4'd0,  exp_product: 0,   exp_lat: 1};
    vecs[4] = '{a: 4'd0,  b: 4'd7,  exp_product: 0,   exp_lat: 8};
    vecs[5] = '{a: 4'd1,  b: 4'd1,  exp_product: 1,   exp_lat: 2};
    vecs[6] = '{a: 4'd15, b: 4'd1,  exp_product: 15,  exp_lat: 2};
    vecs[7] = '{a: 4'd2,  b: 4'd15, exp_product: 30,  exp_lat: 16};

    reset = 1'b1;
    start = 1'b0;
    a_in  = 4'd0;
    b_in  = 4'd0;
    #2;
    chk("reset product", int'(product), 0);
    chk("reset done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    // IDLE with start low: inputs wiggle, nothing changes.
    a_in = 4'd11;
    b_in = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("idle hold product", int'(product), 0);
    chk("idle hold done", int'(done), 0);

    // Table: consecutive entries start straight from DONE (back to back).
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
             vecs[i].exp_product, vecs[i].exp_lat);
    end

    // Start re-pulsed with new operands during CALC must be ignored.
    @(negedge clk);
    start = 1'b1;
    a_in  = 4'd5;
    b_in  = 4'd6;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 0;
    while (cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) break;
      if (cycles == 2) begin
        start = 1'b1;
        a_in  = 4'd2;
        b_in  = 4'd2;
      end else if (cycles == 3) begin
        start = 1'b0;
      end
    end
    chk("restart-ignored latency", cycles, 7);
    chk("restart-ignored product", int'(product), 30);

    // Reset mid-CALC: async clear, start ignored under reset, no late done.
    @(negedge clk);
    start = 1'b1;
    a_in  = 4'd4;
    b_in  = 4'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async reset product", int'(product), 0);
    chk("async reset done", int'(done), 0);
    @(negedge clk);
    start = 1'b1;
    a_in  = 4'd1;
    b_in  = 4'd1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("start under reset done", int'(done), 0);
    chk("start under reset product", int'(product), 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    saw_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    chk("no done after abort", saw_done, 0);
    chk("product after abort", int'(product), 0);

    run_op("post-reset", 4'd2, 4'd3, 6, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/repeated_adder.md
REPEATED_ADDER -- requirements
Module: repeated_adder

Interface
REQ-001 Parameter N, default 4: operand width in bits; product width is 2*N; all requirements below use N=4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiplication, sampled on the rising edge of clk.
REQ-005 A  input  N  multiplicand, unsigned.
REQ-006 B  input  N  multiplier and repeat count, unsigned.
REQ-007 product  output  2N  unsigned result A*B, registered.
REQ-008 done  output  1  high while a valid result is held on product.

Function
REQ-009 The block SHALL be a three-state FSM: IDLE, CALC, DONE.
REQ-010 The block SHALL hold internal registers for latched multiplicand a_reg (N bits), down-counter cnt (N bits), accumulator product (2N bits) and done.
REQ-011 In IDLE or DONE with start=1 at edge k, the block SHALL:
- latch a_reg<=A and cnt<=B
- clear product<=0 and done<=0
- enter CALC.
REQ-012 In IDLE or DONE with start=0, the block SHALL leave all registers unchanged.
REQ-013 In CALC with cnt!=0, each edge SHALL perform product<=product+a_reg (zero-extended to 2N bits) and cnt<=cnt-1.
REQ-014 In CALC with cnt==0, the edge SHALL set done<=1 and enter DONE, with product unchanged.
REQ-015 Latency: done SHALL rise at edge k+B+1 after start is sampled at edge k. Examples: B=0 gives 1 cycle; B=15 gives 16 cycles.
REQ-016 Width rule: the maximum result is 15*15=225, which fits in 8 bits; the accumulator SHALL never overflow.
REQ-017 In DONE, done SHALL stay 1 and product SHALL hold the result until a new start is accepted or reset is asserted.
REQ-018 start SHALL be ignored while in CALC.
REQ-019 Changes on A or B SHALL be ignored after start is sampled; only the latched values are used.
REQ-020 If A=0, product SHALL be 0 when done rises, after B+1 cycles.
REQ-021 If B=0, product SHALL be 0 when done rises, one cycle after start.
REQ-022 A start accepted in DONE SHALL deassert done on the same edge it is sampled (back-to-back operation).

Reset
REQ-023 Asserting reset SHALL immediately force, independent of clk:
- state=IDLE
- product=0, done=0
- a_reg=0, cnt=0.
REQ-024 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow.
REQ-025 While reset is high, start SHALL be ignored.
REQ-026 After reset is released, the first start SHALL be accepted on the next rising edge.

Verification
REQ-027 A=3, B=4, start pulsed for one cycle: done rises 5 cycles later with product=12 (0x0C).
REQ-028 A=7, B=5, start pulsed: done rises after 6 cycles with product=35 (0x23); done stays high until the next start.
REQ-029 A=15, B=15, start pulsed: done rises after 16 cycles with product=225 (0xE1).
REQ-030 A=9, B=0 gives done after 1 cycle with product=0; A=0, B=7 gives done after 8 cycles with product=0.
REQ-031 A=5, B=6, with start re-pulsed and A/B changed to 2/2 during CALC: the result is still 30, and no restart occurs.
REQ-032 Reset asserted 3 cycles into an A=4, B=8 run: product=0 and done=0 immediately; a subsequent start with A=2, B=3 yields 6.
